// File: rtl/recon_pkg.sv
// Shared constants, state encoding and byte helpers for the reconfiguration ICAP writer.
package recon_pkg;

  localparam int ICAP_WIDTH = 32;

  localparam int ERR_SHORT     = 0;
  localparam int ERR_LONG      = 1;
  localparam int ERR_UNALIGNED = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    STATUS = 2'd3
  } state_t;

  function automatic logic [2:0] popcount4(input logic [3:0] k);
    return 3'(k[0]) + 3'(k[1]) + 3'(k[2]) + 3'(k[3]);
  endfunction

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/recon_icap_writer_if.sv
// Bitstream AXI-Stream bundle between the DMA read engine and the ICAP writer.
interface recon_icap_writer_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/recon_word_unpacker.sv
// Holds one stream beat and presents it as byte-ordered 32-bit words, one per advance.
module recon_word_unpacker
  import recon_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  flush,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] tdata,
  input  logic [KEEP_WIDTH-1:0] tkeep,
  input  logic                  tlast,
  output logic                  buf_valid,
  output logic                  word_valid,
  output logic [ICAP_WIDTH-1:0] word,
  output logic [2:0]            word_bytes,
  output logic                  word_last,
  output logic                  beat_tlast
);

  localparam int NUM_WORDS = KEEP_WIDTH / 4;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic [DATA_WIDTH-1:0] data_q;
  logic [KEEP_WIDTH-1:0] keep_q;
  logic [IDX_W-1:0]      idx_q;
  logic [ICAP_WIDTH-1:0] raw;
  logic [3:0]            keep4;
  logic                  last_slot;
  logic                  next_keep;
  int                    nidx;

  always_comb begin
    raw        = data_q[ICAP_WIDTH*int'(idx_q) +: ICAP_WIDTH];
    keep4      = keep_q[4*int'(idx_q) +: 4];
    last_slot  = (int'(idx_q) == NUM_WORDS - 1);
    nidx       = last_slot ? 0 : int'(idx_q) + 1;
    next_keep  = !last_slot && keep_q[4*nidx];
    word       = '0;
    // Lowest-addressed byte lands in the most significant byte of the ICAP word.
    for (int i = 0; i < 4; i++)
      word[ICAP_WIDTH-1-8*i -: 8] = keep4[i] ? raw[8*i +: 8] : 8'h00;
    word_valid = |keep4;
    word_bytes = popcount4(keep4);
    word_last  = !word_valid || !next_keep;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid  <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      keep_q     <= '0;
      beat_tlast <= 1'b0;
    end else if (flush) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      data_q     <= tdata;
      keep_q     <= tkeep;
      beat_tlast <= tlast;
      idx_q      <= '0;
      buf_valid  <= 1'b1;
    end else if (advance && buf_valid) begin
      if (word_last) buf_valid <= 1'b0;
      else           idx_q     <= idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/recon_icap_writer.sv
// Streams a DMA-returned bitstream into the ICAP write port and reports length errors.
// Optional build macro RECON_ICAP_BITSWAP_EN bit-reverses each byte of icap_i.
//
// state  | meaning
// IDLE   | waiting for a command; cmd_ready high
// RUN    | unpacking beats and writing one word per cycle to the ICAP
// DRAIN  | length reached before tlast; discarding beats up to tlast
// STATUS | one-cycle completion report, then back to IDLE
module recon_icap_writer
  import recon_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 20,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [TAG_WIDTH-1:0]  cmd_tag,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  recon_icap_writer_if.slave    s_axis,
  output logic                  icap_csib,
  output logic                  icap_rdwrb,
  output logic [ICAP_WIDTH-1:0] icap_i,
  output logic                  sts_valid,
  output logic [TAG_WIDTH-1:0]  sts_tag,
  output logic [LEN_WIDTH-1:0]  sts_bytes,
  output logic [2:0]            sts_error
);

  state_t                state_q;
  logic [LEN_WIDTH-1:0]  rem_q, bytes_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [2:0]            err_q;

  logic                  buf_valid, word_valid, word_last, beat_tlast;
  logic [ICAP_WIDTH-1:0] word, word_masked, icap_word;
  logic [2:0]            word_bytes;
  logic [LEN_WIDTH-1:0]  take, rem_next;
  logic                  in_run, issue, run_end, tready_c, load;

  recon_word_unpacker #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_unpacker (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .flush      (run_end),
    .advance    (in_run),
    .tdata      (s_axis.tdata),
    .tkeep      (s_axis.tkeep),
    .tlast      (s_axis.tlast),
    .buf_valid  (buf_valid),
    .word_valid (word_valid),
    .word       (word),
    .word_bytes (word_bytes),
    .word_last  (word_last),
    .beat_tlast (beat_tlast)
  );

  always_comb begin
    take        = (rem_q < LEN_WIDTH'(word_bytes)) ? rem_q : LEN_WIDTH'(word_bytes);
    rem_next    = rem_q - take;
    word_masked = word;
    for (int i = 0; i < 4; i++)
      if (rem_q <= LEN_WIDTH'(i)) word_masked[ICAP_WIDTH-1-8*i -: 8] = 8'h00;
  end

`ifdef RECON_ICAP_BITSWAP_EN
  always_comb begin
    icap_word = '0;
    for (int i = 0; i < 4; i++) icap_word[8*i +: 8] = bitrev8(word_masked[8*i +: 8]);
  end
`else
  assign icap_word = word_masked;
`endif

  assign in_run  = (state_q == RUN);
  assign issue   = in_run && buf_valid && word_valid;
  assign run_end = in_run && buf_valid && ((rem_next == '0) || (word_last && beat_tlast));
  // A tlast beat must never pull in the first beat of the following frame.
  assign tready_c = !rst && ((in_run && (!buf_valid ||
                     (word_last && !beat_tlast && (rem_next != '0)))) || (state_q == DRAIN));
  assign load     = in_run && s_axis.tvalid && tready_c;
  assign s_axis.tready = tready_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_ready  <= 1'b0;
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b1;
      icap_i     <= '0;
      sts_valid  <= 1'b0;
      sts_tag    <= '0;
      sts_bytes  <= '0;
      sts_error  <= '0;
      rem_q      <= '0;
      bytes_q    <= '0;
      tag_q      <= '0;
      err_q      <= '0;
    end else begin
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b1;
      sts_valid  <= 1'b0;
      case (state_q)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_ready && cmd_valid) begin
            cmd_ready            <= 1'b0;
            tag_q                <= cmd_tag;
            rem_q                <= cmd_len;
            bytes_q              <= '0;
            err_q                <= '0;
            err_q[ERR_UNALIGNED] <= (cmd_len[1:0] != 2'b00);
            state_q              <= (cmd_len == '0) ? STATUS : RUN;
          end
        end
        RUN: begin
          if (issue) begin
            icap_csib  <= 1'b0;
            icap_rdwrb <= 1'b0;
            icap_i     <= icap_word;
            bytes_q    <= bytes_q + take;
          end
          if (buf_valid) rem_q <= rem_next;
          if (run_end) begin
            if (rem_next == '0 && !beat_tlast) begin
              err_q[ERR_LONG] <= 1'b1;
              state_q         <= DRAIN;
            end else begin
              if (rem_next != '0) err_q[ERR_SHORT] <= 1'b1;
              state_q <= STATUS;
            end
          end
        end
        DRAIN: begin
          if (s_axis.tvalid && s_axis.tlast) state_q <= STATUS;
        end
        STATUS: begin
          sts_valid <= 1'b1;
          sts_tag   <= tag_q;
          sts_bytes <= bytes_q;
          sts_error <= err_q;
          cmd_ready <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recon_icap_writer.sv
// Scoreboard bench for recon_icap_writer; honours RECON_ICAP_BITSWAP_EN the same way as the RTL build.
`timescale 1ns/1ps
module tb_recon_icap_writer;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int LW = 20;
  localparam int TW = 8;
`ifdef RECON_ICAP_BITSWAP_EN
  localparam logic [7:0] BYTE01_EXP = 8'h80;
`else
  localparam logic [7:0] BYTE01_EXP = 8'h01;
`endif

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [LW-1:0] bytes;
    logic [2:0]    err;
  } sts_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [LW-1:0] cmd_len;
  logic [TW-1:0] cmd_tag;
  logic          cmd_valid, cmd_ready;
  logic          icap_csib, icap_rdwrb;
  logic [31:0]   icap_i;
  logic          sts_valid;
  logic [TW-1:0] sts_tag;
  logic [LW-1:0] sts_bytes;
  logic [2:0]    sts_error;

  recon_icap_writer_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_axis ();

  recon_icap_writer #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LEN_WIDTH(LW), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_len(cmd_len), .cmd_tag(cmd_tag), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_axis(s_axis),
    .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .icap_i(icap_i),
    .sts_valid(sts_valid), .sts_tag(sts_tag), .sts_bytes(sts_bytes), .sts_error(sts_error)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_words[$];
  sts_t        exp_sts[$];
  logic [DW-1:0] bd[8];
  logic [KW-1:0] bk[8];
  logic          bl[8];

  bit          mon_en = 1'b1;
  int          word_cnt, cur_run, max_run, sts_cnt;
  logic [31:0] first_word, last_word, mon_exp;
  sts_t        mon_sts, got_sts;

  function automatic logic [7:0] mb(input logic [7:0] b);
    logic [7:0] r;
`ifdef RECON_ICAP_BITSWAP_EN
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
    r = b;
`endif
    return r;
  endfunction

  // Monitor: pops the scoreboard on every ICAP write and every status pulse.
  always @(negedge clk) begin
    if (!rst && !icap_csib) begin
      word_cnt++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      if (word_cnt == 1) first_word = icap_i;
      last_word = icap_i;
      if (mon_en) begin
        checks++;
        if (exp_words.size() == 0) begin
          errors++;
          $display("FAIL icap_word unexpected: got %h rdwrb %b", icap_i, icap_rdwrb);
        end else begin
          mon_exp = exp_words.pop_front();
          if (icap_i !== mon_exp || icap_rdwrb !== 1'b0) begin
            errors++;
            $display("FAIL icap_word #%0d: got %h rdwrb %b, want %h rdwrb 0",
                     word_cnt, icap_i, icap_rdwrb, mon_exp);
          end
        end
      end
    end else begin
      cur_run = 0;
    end
    if (!rst && sts_valid) begin
      sts_cnt++;
      checks++;
      got_sts = '{tag: sts_tag, bytes: sts_bytes, err: sts_error};
      if (exp_sts.size() == 0) begin
        errors++;
        $display("FAIL status unexpected: tag %h bytes %0d err %b", sts_tag, sts_bytes, sts_error);
      end else begin
        mon_sts = exp_sts.pop_front();
        if (got_sts !== mon_sts) begin
          errors++;
          $display("FAIL status: got tag %h bytes %0d err %b, want tag %h bytes %0d err %b",
                   sts_tag, sts_bytes, sts_error, mon_sts.tag, mon_sts.bytes, mon_sts.err);
        end
      end
    end
  end

  // Reference model of the word stream and the final status for beats bd/bk/bl[0..n-1].
  task automatic expect_frame(input int len, input logic [TW-1:0] tag, input int n);
    int rem, bytes, cnt, take;
    logic [2:0] err;
    logic done;
    logic [3:0] k;
    logic [31:0] wd;
    sts_t s;
    rem = len; bytes = 0; err = 3'b000; done = (len == 0);
    err[2] = (len % 4) != 0;
    for (int b = 0; b < n; b++) begin
      for (int w = 0; w < KW / 4; w++) begin
        k = bk[b][4*w +: 4];
        if (k != 4'h0 && !done) begin
          wd = '0; cnt = 0;
          for (int i = 0; i < 4; i++) if (k[i]) begin
            cnt++;
            if (i < rem) wd[8*(3-i) +: 8] = mb(bd[b][32*w + 8*i +: 8]);
          end
          take = (cnt < rem) ? cnt : rem;
          rem -= take; bytes += take;
          exp_words.push_back(wd);
          if (rem == 0) begin done = 1'b1; if (!bl[b]) err[1] = 1'b1; end
        end
      end
      if (!done && bl[b]) begin done = 1'b1; err[0] = 1'b1; end
    end
    s.tag = tag; s.bytes = LW'(bytes); s.err = err;
    exp_sts.push_back(s);
  endtask

  task automatic fill_beat(input int b, input logic [KW-1:0] keep, input logic last);
    for (int j = 0; j < DW / 32; j++) bd[b][32*j +: 32] = $urandom;
    bk[b] = keep;
    bl[b] = last;
  endtask

  task automatic send_cmd(input int len, input logic [TW-1:0] tag);
    int g;
    g = 0;
    @(negedge clk);
    cmd_len = LW'(len); cmd_tag = tag; cmd_valid = 1'b1;
    while (!cmd_ready && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) begin
      checks++; errors++;
      $display("FAIL cmd_accept: cmd_ready stuck at %b, want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drive_frame(input int n, input bit gap);
    int g;
    for (int b = 0; b < n; b++) begin
      s_axis.tdata = bd[b]; s_axis.tkeep = bk[b]; s_axis.tlast = bl[b]; s_axis.tvalid = 1'b1;
      g = 0;
      while (!s_axis.tready && g < 500) begin @(negedge clk); g++; end
      if (g >= 500) begin
        checks++; errors++;
        $display("FAIL beat_accept %0d: tready stuck at %b, want 1", b, s_axis.tready);
      end
      @(negedge clk);
      s_axis.tvalid = 1'b0;
      if (gap) @(negedge clk);
    end
  endtask

  task automatic wait_sts(input int target);
    int g;
    g = 0;
    while (sts_cnt < target && g < 2000) begin @(negedge clk); g++; end
    checks++;
    if (sts_cnt < target) begin
      errors++;
      $display("FAIL sts_timeout: got %0d status pulses, want %0d", sts_cnt, target);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_words.size() != 0) begin
      errors++;
      $display("FAIL words_missing: got %0d left, want 0", exp_words.size());
    end
  endtask

  task automatic start_test();
    word_cnt = 0; max_run = 0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, s_axis.tready, icap_csib, icap_rdwrb, icap_i} !== {4'b0011, 32'h0}) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy %b trdy %b csib %b rdwrb %b icap %h, want 0 0 1 1 0",
               cmd_ready, s_axis.tready, icap_csib, icap_rdwrb, icap_i);
    end
    checks++;
    if ({sts_valid, sts_tag, sts_bytes, sts_error} !== '0) begin
      errors++;
      $display("FAIL reset_sts: got v %b tag %h bytes %0d err %b, want all 0",
               sts_valid, sts_tag, sts_bytes, sts_error);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: got %b, want 1", cmd_ready);
    end
  endtask

  task automatic test_full_beats();
    int base;
    fill_beat(0, '1, 1'b0);
    fill_beat(1, '1, 1'b1);
    expect_frame(128, 8'h5A, 2);
    start_test(); base = sts_cnt;
    send_cmd(128, 8'h5A);
    drive_frame(2, 1'b0);
    wait_sts(base + 1);
    check_int("full_words", word_cnt, 32);
    check_int("full_consecutive", max_run, 32);
    checks++;
    if (first_word !== {mb(bd[0][7:0]), mb(bd[0][15:8]), mb(bd[0][23:16]), mb(bd[0][31:24])}) begin
      errors++;
      $display("FAIL first_word: got %h, want byte-ordered %h", first_word, bd[0][31:0]);
    end
  endtask

  task automatic test_unaligned();
    int base;
    fill_beat(0, '1, 1'b0);
    fill_beat(1, KW'(64'h3F), 1'b1);
    expect_frame(70, 8'h11, 2);
    start_test(); base = sts_cnt;
    send_cmd(70, 8'h11);
    drive_frame(2, 1'b0);
    wait_sts(base + 1);
    check_int("unaligned_words", word_cnt, 18);
    check_int("unaligned_tail_zero", int'(last_word[15:0]), 0);
  endtask

  task automatic test_short();
    int base;
    fill_beat(0, '1, 1'b0);
    fill_beat(1, '1, 1'b1);
    expect_frame(256, 8'h22, 2);
    start_test(); base = sts_cnt;
    send_cmd(256, 8'h22);
    drive_frame(2, 1'b0);
    wait_sts(base + 1);
    check_int("short_words", word_cnt, 32);
  endtask

  task automatic test_long();
    int base;
    fill_beat(0, '1, 1'b0);
    fill_beat(1, '1, 1'b0);
    fill_beat(2, '1, 1'b1);
    expect_frame(64, 8'h44, 3);
    start_test(); base = sts_cnt;
    send_cmd(64, 8'h44);
    drive_frame(3, 1'b0);
    wait_sts(base + 1);
    check_int("long_words", word_cnt, 16);
  endtask

  task automatic test_stall();
    int base;
    for (int b = 0; b < 8; b++) fill_beat(b, KW'(64'hF), b == 7);
    expect_frame(32, 8'h66, 8);
    start_test(); base = sts_cnt;
    send_cmd(32, 8'h66);
    drive_frame(8, 1'b1);
    wait_sts(base + 1);
    check_int("stall_words", word_cnt, 8);
    check_int("stall_gaps", max_run, 1);
  endtask

  task automatic test_zero_len();
    int n;
    bit saw_ready;
    expect_frame(0, 8'h33, 0);
    @(negedge clk);
    cmd_len = '0; cmd_tag = 8'h33; cmd_valid = 1'b1;
    n = 0; saw_ready = 1'b0;
    do begin
      @(negedge clk);
      cmd_valid = 1'b0;
      n++;
      if (s_axis.tready) saw_ready = 1'b1;
    end while (!sts_valid && n < 10);
    check_int("zero_len_latency", n, 2);
    check_int("zero_len_tready", int'(saw_ready), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rst_mid_run();
    int base;
    fill_beat(0, '1, 1'b0);
    send_cmd(128, 8'h77);
    mon_en = 1'b0;
    s_axis.tdata = bd[0]; s_axis.tkeep = '1; s_axis.tlast = 1'b0; s_axis.tvalid = 1'b1;
    repeat (6) @(negedge clk);
    check_int("pre_rst_writing", int'(icap_csib), 0);
    s_axis.tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({icap_csib, sts_valid, cmd_ready} !== 3'b100) begin
      errors++;
      $display("FAIL rst_mid_run: got csib %b sts_valid %b cmd_ready %b, want 1 0 0",
               icap_csib, sts_valid, cmd_ready);
    end
    rst = 1'b0;
    exp_words.delete();
    mon_en = 1'b1;
    @(negedge clk);
    fill_beat(0, '1, 1'b1);
    expect_frame(64, 8'h88, 1);
    start_test(); base = sts_cnt;
    send_cmd(64, 8'h88);
    drive_frame(1, 1'b0);
    wait_sts(base + 1);
    check_int("after_rst_words", word_cnt, 16);
  endtask

  task automatic test_bitswap();
    int base;
    bd[0] = '0; bd[0][7:0] = 8'h01; bk[0] = KW'(64'hF); bl[0] = 1'b1;
    expect_frame(4, 8'h99, 1);
    start_test(); base = sts_cnt;
    send_cmd(4, 8'h99);
    drive_frame(1, 1'b0);
    wait_sts(base + 1);
    check_int("bitswap_byte0", int'(last_word[31:24]), int'(BYTE01_EXP));
  endtask

  initial begin
    cmd_len = '0; cmd_tag = '0; cmd_valid = 1'b0;
    s_axis.tdata = '0; s_axis.tkeep = '0; s_axis.tlast = 1'b0; s_axis.tvalid = 1'b0;
    word_cnt = 0; cur_run = 0; max_run = 0; sts_cnt = 0;
    first_word = '0; last_word = '0;
    test_reset();
    test_full_beats();
    test_unaligned();
    test_short();
    test_long();
    test_stall();
    test_zero_len();
    test_rst_mid_run();
    test_bitswap();
    check_int("status_queue_empty", exp_sts.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
